// File: rtl/svn_seg_bcd_conv.sv
// svn_seg_bcd_conv: sequential binary-to-BCD converter (double dabble, one bit per clock)
// Optional leading-zero blanking on blank_o is enabled by defining SVN_SEG_LZB_EN;
// without it blank_o is tied low and the port list is unchanged.
module svn_seg_bcd_conv #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [WIDTH-1:0]      bin_i,
    input  logic                  bin_valid_i,
    output logic                  bin_ready_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  bcd_valid_o,
    input  logic                  bcd_ready_i,
    output logic                  overflow_o,
    output logic [DIGITS-1:0]     blank_o
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                r_state;
    logic [WIDTH-1:0]      r_shift;
    logic [4*DIGITS-1:0]   r_work;
    logic [4*DIGITS-1:0]   r_bcd;
    logic                  r_ovf_work;
    logic                  r_ovf;
    logic                  r_valid;
    logic                  r_ready;
    logic [CW-1:0]         r_cnt;
    logic [DIGITS-1:0]     r_blank;
    logic [4*DIGITS-1:0]   w_adj;
    logic [4*DIGITS-1:0]   w_next;
    logic                  w_ovf_next;
    logic [DIGITS-1:0]     w_blank;

    genvar d;

    // Add-3 correction per digit, digits are independent (no carry between them)
    for (d = 0; d < DIGITS; d++) begin : g_adj
        assign w_adj[4*d +: 4] = (r_work[4*d +: 4] >= 4'd5) ? r_work[4*d +: 4] + 4'd3 : r_work[4*d +: 4];
    end

    // Working register after the shift; the top bit of the corrected digits falls out
    assign w_next     = {w_adj[4*DIGITS-2:0], r_shift[WIDTH-1]};
    assign w_ovf_next = r_ovf_work | w_adj[4*DIGITS-1];

`ifdef SVN_SEG_LZB_EN
    logic [DIGITS-1:0] w_nz;
    for (d = 0; d < DIGITS; d++) begin : g_lzb
        assign w_nz[d]    = |w_next[4*d +: 4];
        assign w_blank[d] = (d != 0) && ((w_nz >> d) == '0);
    end
`else
    assign w_blank = '0;
`endif

    // Conversion FSM; results and flags are registered on DONE entry and held afterwards
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_work     <= '0;
            r_bcd      <= '0;
            r_ovf_work <= 1'b0;
            r_ovf      <= 1'b0;
            r_valid    <= 1'b0;
            r_ready    <= 1'b1;
            r_cnt      <= '0;
            r_blank    <= '0;
        end else begin
            case (r_state)
                IDLE: if (bin_valid_i && r_ready) begin
                    r_shift    <= bin_i;
                    r_work     <= '0;
                    r_ovf_work <= 1'b0;
                    r_cnt      <= CW'(WIDTH);
                    r_ready    <= 1'b0;
                    r_state    <= SHIFT;
                end
                SHIFT: begin
                    r_work     <= w_next;
                    r_shift    <= r_shift << 1;
                    r_ovf_work <= w_ovf_next;
                    r_cnt      <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_bcd   <= w_next;
                        r_ovf   <= w_ovf_next;
                        r_blank <= w_blank;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: if (bcd_ready_i) begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bin_ready_o = r_ready;
    assign bcd_o       = r_bcd;
    assign bcd_valid_o = r_valid;
    assign overflow_o  = r_ovf;
    assign blank_o     = r_blank;
endmodule

// File: tb/tb_svn_seg_bcd_conv.sv
// tb_svn_seg_bcd_conv: directed table-driven bench for svn_seg_bcd_conv (16/5 and 8/2 instances)
module tb_svn_seg_bcd_conv;
`ifdef SVN_SEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd;
        logic        ovf;
        logic [4:0]  blank;
    } vec16_t;

    typedef struct {
        logic [7:0] bin;
        logic [7:0] bcd;
        logic       ovf;
        logic [1:0] blank;
    } vec8_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [15:0] b16;
    logic        bv16, br16, bval16, brdy16, ov16;
    logic [19:0] bcd16;
    logic [4:0]  bl16;
    logic [7:0]  b8;
    logic        bv8, br8, bval8, brdy8, ov8;
    logic [7:0]  bcd8;
    logic [1:0]  bl8;

    int pass = 0;
    int total = 0;

    svn_seg_bcd_conv #(.WIDTH(16), .DIGITS(5)) u_dut (
        .clk_i(clk), .rstn_i(rstn), .bin_i(b16), .bin_valid_i(bv16), .bin_ready_o(br16),
        .bcd_o(bcd16), .bcd_valid_o(bval16), .bcd_ready_i(brdy16), .overflow_o(ov16), .blank_o(bl16)
    );

    svn_seg_bcd_conv #(.WIDTH(8), .DIGITS(2)) u_dut8 (
        .clk_i(clk), .rstn_i(rstn), .bin_i(b8), .bin_valid_i(bv8), .bin_ready_o(br8),
        .bcd_o(bcd8), .bcd_valid_o(bval8), .bcd_ready_i(brdy8), .overflow_o(ov8), .blank_o(bl8)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) pass++;
        else $display("FAIL %s: got %0h expected %0h", n, a, e);
    endtask

    task automatic wait16(output int lat);
        lat = 0;
        while (!bval16 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic conv16(input logic [15:0] v, output int lat);
        int n = 0;
        @(negedge clk); b16 = v; bv16 = 1'b1;
        while (!br16 && n < 100) begin
            @(negedge clk); n++;
        end
        @(posedge clk); #1; bv16 = 1'b0;
        wait16(lat);
    endtask

    task automatic conv8(input logic [7:0] v, output int lat);
        int n = 0;
        @(negedge clk); b8 = v; bv8 = 1'b1;
        while (!br8 && n < 100) begin
            @(negedge clk); n++;
        end
        @(posedge clk); #1; bv8 = 1'b0;
        lat = 0;
        while (!bval8 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic release16();
        @(negedge clk); brdy16 = 1'b1;
        @(posedge clk); #1; brdy16 = 1'b0;
    endtask

    task automatic release8();
        @(negedge clk); brdy8 = 1'b1;
        @(posedge clk); #1; brdy8 = 1'b0;
    endtask

    initial begin
        vec16_t t16[7];
        vec8_t  t8[5];
        int lat;
        bit ok;
        t16[0] = '{16'd65535, 20'h65535, 1'b0, 5'b00000};
        t16[1] = '{16'd42,    20'h00042, 1'b0, 5'b11100};
        t16[2] = '{16'd0,     20'h00000, 1'b0, 5'b11110};
        t16[3] = '{16'd1,     20'h00001, 1'b0, 5'b11110};
        t16[4] = '{16'd100,   20'h00100, 1'b0, 5'b11000};
        t16[5] = '{16'd10000, 20'h10000, 1'b0, 5'b00000};
        t16[6] = '{16'd9999,  20'h09999, 1'b0, 5'b10000};
        t8[0]  = '{8'd255, 8'h55, 1'b1, 2'b00};
        t8[1]  = '{8'd99,  8'h99, 1'b0, 2'b00};
        t8[2]  = '{8'd100, 8'h00, 1'b1, 2'b10};
        t8[3]  = '{8'd0,   8'h00, 1'b0, 2'b10};
        t8[4]  = '{8'd37,  8'h37, 1'b0, 2'b00};

        rstn = 1'b0; b16 = '0; bv16 = 1'b0; brdy16 = 1'b0; b8 = '0; bv8 = 1'b0; brdy8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bcd", bcd16, 20'h0);
        chk("rst_valid", bval16, 1'b0);
        chk("rst_ready", br16, 1'b1);
        chk("rst_ovf", ov16, 1'b0);
        chk("rst_blank", bl16, 5'b0);
        chk("rst_ready8", br8, 1'b1);
        @(negedge clk); rstn = 1'b1;

        for (int i = 0; i < 7; i++) begin
            conv16(t16[i].bin, lat);
            chk("lat16", lat, 16);
            chk("bcd16", bcd16, t16[i].bcd);
            chk("ovf16", ov16, t16[i].ovf);
            chk("blank16", bl16, LZB ? t16[i].blank : 5'b0);
            chk("busy16", br16, 1'b0);
            release16();
            chk("drop16", bval16, 1'b0);
            chk("hold16", bcd16, t16[i].bcd);
            chk("rdy16", br16, 1'b1);
        end

        for (int i = 0; i < 5; i++) begin
            conv8(t8[i].bin, lat);
            chk("lat8", lat, 8);
            chk("bcd8", bcd8, t8[i].bcd);
            chk("ovf8", ov8, t8[i].ovf);
            chk("blank8", bl8, LZB ? t8[i].blank : 2'b0);
            release8();
            chk("drop8", bval8, 1'b0);
            chk("hold8", bcd8, t8[i].bcd);
        end

        conv16(16'd42, lat);
        chk("bp_lat", lat, 16);
        b16 = 16'd7; bv16 = 1'b1; ok = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (bcd16 !== 20'h00042 || bval16 !== 1'b1 || br16 !== 1'b0) ok = 1'b0;
        end
        chk("bp_hold", ok, 1'b1);
        @(negedge clk); brdy16 = 1'b1;
        @(posedge clk); #1; brdy16 = 1'b0;
        chk("bp_drop", bval16, 1'b0);
        chk("bp_ready", br16, 1'b1);
        chk("bp_retain", bcd16, 20'h00042);
        @(posedge clk); #1; bv16 = 1'b0;
        chk("bp_accept_idle", br16, 1'b0);
        wait16(lat);
        chk("bp_lat2", lat, 16);
        chk("bp_bcd2", bcd16, 20'h00007);
        release16();

        @(negedge clk); b16 = 16'd9999; bv16 = 1'b1;
        @(posedge clk); #1; bv16 = 1'b0;
        repeat (6) @(posedge clk);
        #2; rstn = 1'b0;
        #1;
        chk("abort_valid", bval16, 1'b0);
        chk("abort_ready", br16, 1'b1);
        chk("abort_bcd", bcd16, 20'h0);
        chk("abort_ovf", ov16, 1'b0);
        ok = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (bval16 !== 1'b0 || br16 !== 1'b1 || bcd16 !== 20'h0 || ov16 !== 1'b0) ok = 1'b0;
        end
        chk("abort_hold", ok, 1'b1);
        @(negedge clk); rstn = 1'b1;
        ok = 1'b1;
        repeat (25) begin
            @(posedge clk); #1;
            if (bval16 !== 1'b0) ok = 1'b0;
        end
        chk("abort_no_pulse", ok, 1'b1);
        conv16(16'd1234, lat);
        chk("post_lat", lat, 16);
        chk("post_bcd", bcd16, 20'h01234);
        chk("post_blank", bl16, LZB ? 5'b10000 : 5'b0);
        release16();

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
